// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//
// Builds an A_W x B_W unsigned product from one small combinational 2x3
// multiplier core (m[1:0] x q[2:0] -> pp[4:0]). The controller walks every
// (A-digit, B-digit) pair, one pair per clock, and adds the partial product
// shifted by its digit weight (2*i + 3*j) into an A_W+B_W bit accumulator.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; aborts any operation silently
//   start  - request pulse, sampled only while busy = 0
//   a      - multiplicand (A_W bits, A_W a multiple of 2), captured on accept
//   b      - multiplier   (B_W bits, B_W a multiple of 3), captured on accept
//   busy   - high from the accept edge through the done cycle
//   done   - one-cycle completion pulse
//   p      - registered product, held until the next completion
//
// Optional feature (macro MULT_SEQ_SKIP_ZERO_EN):
//   When defined, a zero A-digit skips its whole row in a single cycle, so
//   latency varies from NA to NA*NB cycles. When undefined, latency is always
//   NA*NB cycles.
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int A_W = 6,
    parameter int B_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               busy,
    output logic               done,
    output logic [A_W+B_W-1:0] p
);

    localparam int PW = A_W + B_W;
    localparam int NA = A_W / 2;
    localparam int NB = B_W / 3;
    localparam int IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int JW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(NA - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    logic [A_W-1:0] a_reg;
    logic [B_W-1:0] b_reg;
    logic [PW-1:0]  acc;
    logic [IW-1:0]  i;
    logic [JW-1:0]  j;

    // Shared multiplier core and shift-add datapath for the current pair.
    logic [1:0]    m;
    logic [2:0]    q;
    logic [4:0]    pp;
    int unsigned   shamt;
    logic [PW-1:0] acc_next;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here, unconditionally at the top) so no latch can be inferred.
    always_comb begin
        m        = a_reg[2*i +: 2];
        q        = b_reg[3*j +: 3];
        pp       = 5'(m) * 5'(q);
        shamt    = 2 * int'(i) + 3 * int'(j);
        acc_next = acc + (PW'(pp) << shamt);
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
                    if (m == 2'b00) begin
                        // Every pair in this row contributes zero: skip the
                        // row, leaving the accumulator untouched.
                        j <= '0;
                        if (i == I_LAST) begin
                            p     <= acc;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            i <= i + IW'(1);
                        end
                    end else
`endif
                    begin
                        acc <= acc_next;
                        if (j == J_LAST) begin
                            j <= '0;
                            if (i == I_LAST) begin
                                // Last pair: publish the final sum directly,
                                // p keeps the previous product until now.
                                p     <= acc_next;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                i <= i + IW'(1);
                            end
                        end else begin
                            j <= j + JW'(1);
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
//
// Directed self-checking bench for mult_seq_ctrl (A_W = B_W = 6). Expected
// products and latencies are hand-computed constants. Outputs are sampled on
// the falling edge; inputs are driven on the falling edge.
// Latency expectations follow MULT_SEQ_SKIP_ZERO_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  a_i;
    logic [5:0]  b_i;
    logic        busy;
    logic        done;
    logic [11:0] p;

    int errors = 0;
    int checks = 0;

`ifdef MULT_SEQ_SKIP_ZERO_EN
    localparam int LAT_ZERO_A = 3;   // a=0: three rows skipped
    localparam int BB_FIRST   = 5;   // a=7: last digit 00 skipped
    localparam int BB_SECOND  = 11;  // a=2: accepted at 7, 2+1+1 cycles
`else
    localparam int LAT_ZERO_A = 6;
    localparam int BB_FIRST   = 6;
    localparam int BB_SECOND  = 14;
`endif

    mult_seq_ctrl #(
        .A_W(6),
        .B_W(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a_i),
        .b    (b_i),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation; lat is the number of edges after acceptance at
    // which done was first seen (-1 if it never came within the budget).
    // Returns after the edge following done.
    task automatic do_op(input logic [5:0] av, input logic [5:0] bv,
                         output int lat, output logic [11:0] prod,
                         output logic busy_at_done);
        @(negedge clk);
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat          = -1;
        prod         = 'x;
        busy_at_done = 1'bx;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat          = e;
                prod         = p;
                busy_at_done = busy;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b p=%0d, want 0 0 0", busy, done, p);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Reset and start together: reset must win.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        a_i   = 6'd45;
        b_i   = 6'd27;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_start: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        int          lat;
        logic [11:0] prod;
        logic        bz;
        do_op(6'd45, 6'd27, lat, prod, bz);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 6", lat);
        end
        checks++;
        if (prod !== 12'd1215) begin
            errors++;
            $display("FAIL basic_product: got %0d, want 1215", prod);
        end
        checks++;
        if (bz !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_in_done: got %b, want 1", bz);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 12'd1215) begin
            errors++;
            $display("FAIL basic_after_done: busy=%b done=%b p=%0d, want 0 0 1215", busy, done, p);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        @(negedge clk);
        a_i   = 6'd45;
        b_i   = 6'd27;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy_before_reset: got %b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 12'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b p=%0d, want 0 0 0", busy, done, p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: dones=%0d busy=%b, want 0 0", dones, busy);
        end
    endtask

    task automatic test_extremes();
        int          lat;
        logic [11:0] prod;
        logic        bz;
        do_op(6'd63, 6'd63, lat, prod, bz);
        checks++;
        if (prod !== 12'd3969 || lat !== 6) begin
            errors++;
            $display("FAIL extreme_max: p=%0d lat=%0d, want 3969 6", prod, lat);
        end
        do_op(6'd0, 6'd63, lat, prod, bz);
        checks++;
        if (prod !== 12'd0) begin
            errors++;
            $display("FAIL extreme_zero_product: got %0d, want 0", prod);
        end
        checks++;
        if (lat !== LAT_ZERO_A) begin
            errors++;
            $display("FAIL extreme_zero_latency: got %0d, want %0d", lat, LAT_ZERO_A);
        end
    endtask

    task automatic test_busy_protect();
        int dones = 0;
        @(negedge clk);
        a_i   = 6'd45;
        b_i   = 6'd27;
        start = 1'b1;
        @(posedge clk);                // edge 0: accepted
        @(negedge clk);
        start = 1'b0;
        a_i   = 6'd0;                  // operand changes after accept
        b_i   = 6'd0;
        @(posedge clk);                // edge 1
        @(negedge clk);
        start = 1'b1;
        a_i   = 6'd1;
        b_i   = 6'd1;
        @(posedge clk);                // edge 2: must be ignored
        @(negedge clk);
        start = 1'b0;
        for (int e = 3; e <= 6; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (done !== 1'b1 || p !== 12'd1215) begin
            errors++;
            $display("FAIL busy_done_edge6: done=%b p=%0d, want 1 1215", done, p);
        end
        start = 1'b1;                  // start during the DONE cycle
        @(posedge clk);                // edge 7: must be ignored
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_in_done: busy=%b done=%b, want 0 0", busy, done);
        end
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 1 || p !== 12'd1215) begin
            errors++;
            $display("FAIL busy_single_done: dones=%0d p=%0d, want 1 1215", dones, p);
        end
    endtask

    task automatic test_back_to_back();
        int first  = -1;
        int second = -1;
        @(negedge clk);
        a_i   = 6'd7;
        b_i   = 6'd9;
        start = 1'b1;
        for (int e = 0; e <= BB_SECOND + 1; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 0) begin
                a_i = 6'd2;
                b_i = 6'd5;
            end
            if (done === 1'b1) begin
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
            if (e == BB_FIRST) begin
                checks++;
                if (p !== 12'd63) begin
                    errors++;
                    $display("FAIL b2b_first_product: got %0d, want 63", p);
                end
            end
            if (e == BB_FIRST + 1) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_gap: busy=%b done=%b, want 0 0", busy, done);
                end
            end
            if (e == BB_FIRST + 2) begin
                checks++;
                if (busy !== 1'b1 || p !== 12'd63) begin
                    errors++;
                    $display("FAIL b2b_second_accept: busy=%b p=%0d, want 1 63", busy, p);
                end
            end
            if (e == BB_SECOND) begin
                checks++;
                if (p !== 12'd10) begin
                    errors++;
                    $display("FAIL b2b_second_product: got %0d, want 10", p);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (first !== BB_FIRST || second !== BB_SECOND) begin
            errors++;
            $display("FAIL b2b_done_edges: got %0d %0d, want %0d %0d",
                     first, second, BB_FIRST, BB_SECOND);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_after: busy=%b, want 0", busy);
        end
    endtask

`ifdef MULT_SEQ_SKIP_ZERO_EN
    task automatic test_skip_zero();
        int          lat;
        logic [11:0] prod;
        logic        bz;
        do_op(6'd0, 6'd5, lat, prod, bz);
        checks++;
        if (lat !== 3 || prod !== 12'd0) begin
            errors++;
            $display("FAIL skip_all_rows: lat=%0d p=%0d, want 3 0", lat, prod);
        end
        do_op(6'd48, 6'd5, lat, prod, bz);
        checks++;
        if (lat !== 4 || prod !== 12'd240) begin
            errors++;
            $display("FAIL skip_two_rows: lat=%0d p=%0d, want 4 240", lat, prod);
        end
        do_op(6'd45, 6'd27, lat, prod, bz);
        checks++;
        if (lat !== 6 || prod !== 12'd1215) begin
            errors++;
            $display("FAIL skip_none: lat=%0d p=%0d, want 6 1215", lat, prod);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_extremes();
        test_busy_protect();
        test_back_to_back();
`ifdef MULT_SEQ_SKIP_ZERO_EN
        test_skip_zero();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencing controller that computes an A_W x B_W unsigned product by iterating one shared combinational 2x3 multiplier core (m[1:0] x q[2:0] -> p[4:0]) over all operand digit pairs.
- Each partial product is shifted and added into an accumulator.
- Sits between a host issuing start/operands and the small multiplier datapath, so the team can build wide products from the existing small core.

Parameters:
- A_W, 6, width of operand a; must be a multiple of 2 (2-bit digits feed core input m).
- B_W, 6, width of operand b; must be a multiple of 3 (3-bit digits feed core input q).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- a  input  A_W  multiplicand; captured on accepted start.
- b  input  B_W  multiplier; captured on accepted start.
- busy  output  1  high while an operation is in progress, including the DONE cycle.
- done  output  1  one-cycle completion pulse.
- p  output  A_W+B_W  product; registered, held until the next completion.

Behaviour:
- Interface rule: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, p=0.
  - Operand registers, accumulator, digit indices i/j all 0.
  - Reset mid-operation aborts the operation with no completion pulse.
- Constants:
  - NA=A_W/2 A-digits; NB=B_W/3 B-digits; N=NA*NB pairs.
  - Defaults: NA=3, NB=2, N=6.
- FSM:
  - IDLE: on edge with start=1, latch a/b, acc=0, i=0, j=0, go to RUN, busy=1.
  - RUN: each edge, the core evaluates m=a_reg[2i+1:2i], q=b_reg[3j+2:3j].
    - acc <= acc + (pp << (2i+3j)), with pp zero-extended to A_W+B_W bits.
    - j increments; when j=NB-1, j wraps to 0 and i increments.
    - On the edge processing the last pair (i=NA-1, j=NB-1): p <= acc+shifted pp, done <= 1, go to DONE.
  - DONE: next edge sets done=0, busy=0, state=IDLE.
- Latency: start accepted at edge 0; done high between edges N and N+1; busy high from after edge 0 until after edge N+1.
- start while busy=1 (RUN or DONE) is ignored; a/b changes after acceptance have no effect.
- Back-to-back: start may be accepted on the edge immediately after done falls (busy=0 in that cycle).
- Arithmetic: unsigned only; accumulator is A_W+B_W bits and cannot overflow.
- p changes only at completion; it retains the old product during a new operation.
- rst_n asserted in the same cycle as start: reset wins.

Optional Feature:
- Macro: MULT_SEQ_SKIP_ZERO_EN.
- Defined: in RUN, if the current A-digit is 0, the whole row is skipped in one cycle (i increments, j=0, acc unchanged).
  - If that zero digit is the last row, that cycle completes the operation.
  - Latency becomes variable, from NA up to N cycles.
- Undefined: fixed latency N for every operand pair; zero digits are processed normally.

Test Plan:
1. Reset: rst_n=0 mid-RUN (a=45, b=27, after 3 edges) -> busy=0, done=0, p=0 immediately; no done pulse after release.
2. Basic: a=45, b=27, start for 1 cycle -> done high exactly 6 edges after acceptance, p=1215, busy low one edge later.
3. Extremes: a=63, b=63 -> p=3969. Then a=0, b=63 -> p=0; without the macro, latency is still 6.
4. Busy protection: during the a=45/b=27 run, pulse start with a=1, b=1 at edge 2 and at the DONE cycle -> both ignored, p=1215, single done pulse.
5. Back-to-back: start held high continuously with a=7, b=9 then a=2, b=5 -> p=63, then p=10; second acceptance on the edge after done falls; p holds 63 until the second done.
6. With MULT_SEQ_SKIP_ZERO_EN: a=0, b=5 -> done after 3 edges, p=0. a=48, b=5 -> done after 4 edges, p=240. a=45, b=27 -> 6 edges, p=1215.
